// File: rtl/fifo_rd_drain_if.sv
// Valid/ready stream carrying drained FIFO words. The master drives valid and data.
// The slave drives ready.
interface fifo_rd_drain_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // A word transfers on every rising edge where valid && ready. While valid is
    // high, data holds steady until that edge. valid never waits on ready.
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side drain of the async FIFO. It absorbs the one-cycle read latency in a
// 3-entry skid buffer and presents a valid/ready stream.
// Optional statistics counters are enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_drain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_rd_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_rd_en,
    input  logic [WIDTH-1:0] i_rdata,
    input  logic             i_empty,
    input  logic             i_rd_error,
    fifo_rd_drain_if.master  m_stream,
    output logic             o_busy,
    output logic             o_err,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [1:0]       o_dbg_state,
    output logic [1:0]       o_dbg_occ,
    output logic             o_dbg_inf
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_occ;
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic             r_inf;
    logic             r_busy;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [3];

    logic       w_push;
    logic       w_pop;
    logic [2:0] w_reserved;
    logic       w_rd_en;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Buffered words plus the one in flight must fit the 3 slots, so a pop is
    // only issued when a slot is guaranteed when its data returns.
    assign w_reserved = {1'b0, r_occ} + {2'b00, r_inf};
    assign w_rd_en    = i_en && (r_state == S_ACTIVE) && !i_empty && (w_reserved < 3'd3);
    assign w_push     = r_inf;
    assign w_pop      = (r_occ != 2'd0) && m_stream.ready;

    always_ff @(posedge i_rd_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_occ   <= 2'd0;
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_inf   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 3; i++) r_mem[i] <= '0;
        end else begin
            r_inf  <= w_rd_en;
            r_busy <= (r_state != S_IDLE);
            if (i_rd_error) r_err <= 1'b1;

            if (w_push) begin
                r_mem[r_tail] <= i_rdata;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_pop) r_head <= next_ptr(r_head);

            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            case (r_state)
                S_IDLE:   if (i_en) r_state <= S_ACTIVE;
                S_ACTIVE: if (!i_en) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (i_en)                            r_state <= S_ACTIVE;
                    else if (!r_inf && r_occ == 2'd0)    r_state <= S_IDLE;
                end
                default:  r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // word_cnt wraps freely; err_cnt sticks at all-ones.
    always_ff @(posedge i_rd_clk) begin
        if (!i_rst) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_pop) r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (i_rd_error && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign o_word_cnt = r_word_cnt;
    assign o_err_cnt  = r_err_cnt;
`else
    assign o_word_cnt = '0;
    assign o_err_cnt  = '0;
`endif

    assign o_rd_en        = w_rd_en;
    assign m_stream.valid = (r_occ != 2'd0);
    assign m_stream.data  = r_mem[r_head];
    assign o_busy         = r_busy;
    assign o_err          = r_err;
    assign o_dbg_state    = r_state;
    assign o_dbg_occ      = r_occ;
    assign o_dbg_inf      = r_inf;
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO model, stream scoreboard, streaming vector
// table and hand sequences for backpressure, drain, error and mid-run reset.
module tb_fifo_rd_drain;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rd_en;
    logic [7:0]  f_rdata = 8'h00;
    logic        f_empty;
    logic        rd_error = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_occ;
    logic        dbg_inf;

    fifo_rd_drain_if #(.WIDTH(8)) m_if ();

    fifo_rd_drain #(.WIDTH(8), .CNT_W(16)) dut (
        .i_rd_clk   (clk),
        .i_rst      (rst_n),
        .i_en       (en),
        .o_rd_en    (rd_en),
        .i_rdata    (f_rdata),
        .i_empty    (f_empty),
        .i_rd_error (rd_error),
        .m_stream   (m_if),
        .o_busy     (busy),
        .o_err      (err),
        .o_word_cnt (word_cnt),
        .o_err_cnt  (err_cnt),
        .o_dbg_state(dbg_state),
        .o_dbg_occ  (dbg_occ),
        .o_dbg_inf  (dbg_inf)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: data appears the cycle after a pop.
    logic [7:0] fmem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign f_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd_en && !f_empty) begin
            f_rdata <= fmem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end
    end

    int n_tests = 0;
    int n_fail = 0;
    int delivered = 0;
    int pop_cnt = 0;
    int viol = 0;
    logic first_pending = 1'b0;
    logic [7:0] first_word = 8'h00;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (rst_n && m_if.valid && m_if.ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got %0h expected no word", m_if.data);
            end else begin
                exp_w = exp_q.pop_front();
                if (m_if.data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0h expected %0h", m_if.data, exp_w);
                end
            end
            delivered++;
            if (first_pending) begin
                first_word    = m_if.data;
                first_pending = 1'b0;
            end
        end
        if (rst_n && rd_en) begin
            pop_cnt++;
            if (f_empty) viol++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic       rdy;
        logic       e_rd_en;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
    } vec_t;
    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(w);
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        m_if.ready = 1'b0;
        rd_error = 1'b0;
        tick();
        tick();
        flush();
        delivered = 0;
        pop_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h15, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        m_if.ready = 1'b0;
        do_reset();

        // Reset values
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", m_if.valid, 0);
        chk("rst_data", m_if.data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_occ", dbg_occ, 0);
        chk("rst_inf", dbg_inf, 0);
        tick();

        // Streaming: five words through the vector table
        for (int i = 0; i < 5; i++) load(8'h11 + 8'(i));
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            m_if.ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("stream_rd_en[%0d]", i), rd_en, vecs[i].e_rd_en);
            chk($sformatf("stream_valid[%0d]", i), m_if.valid, vecs[i].e_valid);
            chk($sformatf("stream_busy[%0d]", i), busy, vecs[i].e_busy);
            if (vecs[i].e_valid) chk($sformatf("stream_data[%0d]", i), m_if.data, vecs[i].e_data);
            tick();
        end
        chk("stream_pops", pop_cnt, 5);
        chk("stream_word_cnt", word_cnt, STATS ? 5 : 0);
        chk("stream_left", exp_q.size(), 0);

        // Backpressure: six words queued, consumer stalled
        do_reset();
        for (int i = 0; i < 6; i++) load(8'h21 + 8'(i));
        en = 1'b1;
        begin
            int unstable;
            unstable = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (m_if.valid && m_if.data !== 8'h21) unstable++;
                tick();
            end
            chk("bp_stable", unstable, 0);
        end
        chk("bp_pops", pop_cnt, 3);
        @(negedge clk);
        chk("bp_occ", dbg_occ, 3);
        chk("bp_inf", dbg_inf, 0);
        chk("bp_rd_en", rd_en, 0);
        chk("bp_data", m_if.data, 8'h21);
        tick();
        m_if.ready = 1'b1;
        wait_drained("bp_drained", 40);
        chk("bp_delivered", delivered, 6);

        // Simultaneous push and pop with occ=2, inf=1
        do_reset();
        for (int i = 0; i < 4; i++) load(8'h31 + 8'(i));
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick();
        end
        m_if.ready = 1'b1;
        @(negedge clk);
        chk("sim_occ_before", dbg_occ, 2);
        chk("sim_inf_before", dbg_inf, 1);
        chk("sim_rd_en", rd_en, 0);
        chk("sim_data", m_if.data, 8'h31);
        tick();
        @(negedge clk);
        chk("sim_occ_after", dbg_occ, 2);
        chk("sim_data_next", m_if.data, 8'h32);
        tick();
        wait_drained("sim_drained", 40);
        chk("sim_delivered", delivered, 4);

        // Drain: en dropped with two buffered and one in flight
        do_reset();
        for (int i = 0; i < 4; i++) load(8'h41 + 8'(i));
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("drain_rd_en_on", rd_en, 1);
        tick();
        en = 1'b0;
        @(negedge clk);
        chk("drain_rd_en_off", rd_en, 0);
        chk("drain_occ", dbg_occ, 2);
        chk("drain_inf", dbg_inf, 1);
        tick();
        m_if.ready = 1'b1;
        @(negedge clk);
        chk("drain_state", dbg_state, 2);
        chk("drain_busy", busy, 1);
        chk("drain_occ3", dbg_occ, 3);
        tick();
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("drain_idle", dbg_state, 0);
        chk("drain_busy_off", busy, 0);
        chk("drain_valid_off", m_if.valid, 0);
        chk("drain_delivered", delivered, 3);
        chk("drain_left", exp_q.size(), 1);
        tick();

        // Error: two rd_error pulses
        do_reset();
        @(negedge clk);
        chk("err_clear", err, 0);
        tick();
        rd_error = 1'b1;
        tick();
        rd_error = 1'b0;
        @(negedge clk);
        chk("err_set", err, 1);
        tick();
        rd_error = 1'b1;
        tick();
        rd_error = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_cnt", err_cnt, STATS ? 2 : 0);
        tick();

        // Reset with three words buffered
        flush();
        delivered = 0;
        for (int i = 0; i < 7; i++) load(8'h50 + 8'(i));
        en = 1'b1;
        m_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick();
        end
        m_if.ready = 1'b1;
        @(negedge clk);
        tick();
        m_if.ready = 1'b0;
        @(negedge clk);
        chk("mid_rd_en", rd_en, 1);
        tick();
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_occ", dbg_occ, 3);
        chk("mid_head", m_if.data, 8'h51);
        chk("mid_err", err, 1);
        chk("mid_word_cnt", word_cnt, STATS ? 1 : 0);
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        exp_q.delete();
        begin
            logic [7:0] p;
            p = rd_ptr;
            while (p != wr_ptr) begin
                exp_q.push_back(fmem[p]);
                p = p + 8'd1;
            end
        end
        delivered = 0;
        first_pending = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", m_if.valid, 0);
        chk("mid_rst_data", m_if.data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_occ", dbg_occ, 0);
        chk("mid_rst_inf", dbg_inf, 0);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_remaining", exp_q.size(), 3);
        tick();
        en = 1'b1;
        m_if.ready = 1'b1;
        wait_drained("mid_drained", 40);
        chk("mid_first_word", first_word, 8'h54);
        chk("mid_delivered", delivered, 3);
        en = 1'b0;
        tick();

        chk("no_rd_en_when_empty", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain stage on the `rd_clk` domain of the async FIFO. It pops words whenever the FIFO is non-empty and downstream space exists, and absorbs the FIFO's one-cycle read latency in a 3-entry skid buffer. It presents the data as a valid/ready stream, so consumers never handle `empty`, `rd_en` or `rd_error` directly.

## Interface

- `WIDTH`, default 8: data width; must match the FIFO's `WIDTH`.
- `CNT_W`, default 16: width of the statistics counters.

- `rd_clk` in 1: read-domain clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-low.
- `en` in 1: drain enable.
- `rd_en` out 1: FIFO pop request.
- `rdata` in WIDTH: FIFO read data, valid the cycle after `rd_en`.
- `empty` in 1: FIFO empty flag.
- `rd_error` in 1: FIFO read-while-empty error pulse.
- `m_valid` out 1: stream data valid.
- `m_ready` in 1: stream consumer ready.
- `m_data` out WIDTH: stream data.
- `busy` out 1: high in ACTIVE or DRAIN.
- `err` out 1: sticky; set on any `rd_error`.
- `word_cnt` out CNT_W: words delivered on the stream.
- `err_cnt` out CNT_W: `rd_error` pulses seen.

## Operation

- **Buffer**
  - 3-entry circular buffer with occupancy `occ` (0..3).
  - `inf` is `rd_en` registered: one read in flight.
- **Pop rule (combinational)**
  - `rd_en = en && state != IDLE_BLOCK && !empty && (occ + inf < 3)`.
  - `rd_en` never asserts while `empty` is high.
  - `rd_en` drops in the same cycle `en` drops.
- **Push**
  - At an edge with `inf == 1`, `rdata` is written at the tail.
- **Stream**
  - `m_valid = (occ != 0)`; `m_data` is the head entry.
  - Pop on `m_valid && m_ready`.
  - Simultaneous push and pop in one edge leaves `occ` unchanged.
  - `m_data` is stable while `m_valid && !m_ready`.
  - Order is strictly preserved.
- **State machine**
  - IDLE: `en` = 1 → ACTIVE.
  - ACTIVE: `en` = 0 → DRAIN.
  - DRAIN: no new pops. `en` = 1 → ACTIVE. `inf == 0 && occ == 0` → IDLE.
  - DRAIN still delivers buffered and in-flight words.
  - IDLE_BLOCK in the pop rule denotes DRAIN/IDLE; in those states `rd_en` is 0.
- **Boundaries**
  - `occ` = 3, or `occ` = 2 with `inf` = 1: no pop.
  - FIFO goes empty mid-burst: pops stop, buffered data still drains.
  - `rd_error` at any time sets `err`, which clears only on reset.
  - Reset mid-operation discards buffered and in-flight words. Those words are lost from the FIFO by design.

## Timing

- Reset values (`rst` = 0 at an edge):
  - `state` = IDLE, `occ` = 0, `inf` = 0.
  - `rd_en`, `m_valid`, `busy` and `err` are 0.
  - `m_data`, `word_cnt` and `err_cnt` are 0.
- Latency: `rd_en` high in cycle N; word enters the buffer at the end of N+1; `m_valid` high in cycle N+2.
- Throughput: with `m_ready` held high and FIFO non-empty, one word per cycle after the 2-cycle fill.
- Backpressure: with `m_ready` low, at most 3 words are buffered. `rd_en` stays low while `occ + inf == 3`.
- `busy` is registered: high the cycle after entering ACTIVE, low the cycle after reaching IDLE.

## Configuration

- `FIFO_RD_STATS_EN` defined:
  - `word_cnt` increments on every stream handshake and wraps modulo 2^CNT_W.
  - `err_cnt` increments per `rd_error` cycle and saturates at 2^CNT_W−1.
- Undefined:
  - Counter logic is removed and both ports are tied to 0; the port list is unchanged.
  - `err` is always present.

## Test plan

- **Streaming:** FIFO holds 5 words 0x11..0x15, `en` = 1, `m_ready` = 1.
  - `rd_en` high for 5 cycles.
  - `m_data` delivers 0x11..0x15 on consecutive cycles starting 2 cycles after the first `rd_en`.
  - `word_cnt` = 5.
- **Backpressure:** 6 words queued, `m_ready` = 0 for 10 cycles.
  - Exactly 3 pops; `occ` = 3; `m_data` = first word, stable.
  - Release → all 6 delivered in order; no `rd_en` while `empty`.
- **Drain:** `en` dropped with 2 words buffered and 1 in flight.
  - `rd_en` goes low the same cycle.
  - 3 more words delivered, then IDLE; `busy` = 0.
- **Simultaneous push and pop:** `occ` = 2, `inf` = 1, `m_ready` = 1.
  - `occ` stays 2 and no pop is issued that cycle.
  - Sequence is intact.
- **Error:** pulse `rd_error` twice.
  - `err` = 1 sticky.
  - `err_cnt` = 2 with `FIFO_RD_STATS_EN`, 0 without.
- **Reset mid-operation:** `rst` = 0 with 3 words buffered.
  - Next cycle: all outputs at reset values.
  - After release, the first delivered word is the next FIFO word.
